// File: rtl/uart_arb_pkg.sv
// Shared types and sizes for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int NREQ_MAX = 8;
  localparam int BYTE_W   = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req at or after ptr, wrapping at N.
// Purely combinational; idx/onehot are zero when nothing is requested.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // IW+1 bits hold ptr+k without overflow since both are below N <= 2**IW
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    logic [IW:0] s;
    s = {1'b0, p} + (IW+1)'(k);
    if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
    return s[IW-1:0];
  endfunction

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[wrap_add(ptr, k)]) begin
        any                     = 1'b1;
        idx                     = wrap_add(ptr, k);
        onehot[wrap_add(ptr, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uarttx among NREQ byte producers; grant is same-cycle, byte is presented next cycle.
// Backpressure: one-byte holding register, producers stall while full; UART_ARB_LOCK_EN enables grant locking.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ*BYTE_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [IDW-1:0]         tx_src,
  output logic                   busy
);

  state_t            state, state_nxt;
  logic [BYTE_W-1:0] hold;
  logic [IDW-1:0]    ptr;
  logic              lock_act;

  logic [NREQ-1:0]   cand;
  logic [NREQ-1:0]   pick_oh;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;
  logic              accept;
  logic              tx_fire;

  logic [BYTE_W-1:0] req_byte [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign req_byte[i] = req_data[i*BYTE_W +: BYTE_W];
  end

`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0] src_mask;
  assign src_mask = NREQ'(1) << tx_src;
  // A locked grant narrows the candidates to the current owner only
  assign cand = lock_act ? (req_valid & src_mask) : req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_act <= 1'b0;
    end else if (accept) begin
      lock_act <= req_lock[pick_idx];
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_act    = 1'b0;
  assign cand        = req_valid;
`endif

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_pick (
    .req    (cand),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    tx_fire   = 1'b0;
    unique case (state)
      EMPTY: begin
        req_ready = pick_oh;
        if (pick_any) begin
          accept    = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (tx_ready) begin
          tx_fire   = 1'b1;
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= '0;
      tx_src <= '0;
      ptr    <= '0;
    end else begin
      if (accept) begin
        hold   <= req_byte[pick_idx];
        tx_src <= pick_idx;
      end
      if (tx_fire && !lock_act) begin
        ptr <= (tx_src == IDW'(NREQ-1)) ? '0 : tx_src + IDW'(1);
      end
    end
  end

  assign tx_valid = (state == FULL);
  assign tx_data  = hold;
  assign busy     = (state == FULL) | lock_act;

endmodule
